// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: sequences the shared AXI3 AR/R channel between inst and data caches, one burst outstanding.
// Define AXI_ARB_RR_EN for round-robin tie breaking; default build gives data fixed priority.
module axi_read_arbiter #(
    parameter logic [3:0] INST_BURST_LEN = 4'd15,
    parameter logic [3:0] DATA_BURST_LEN = 4'd15
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_cache_ena_i,
    input  logic        inst_arvalid_i,
    input  logic [31:0] inst_araddr_i,
    output logic        inst_arready_o,
    output logic [31:0] inst_rdata_o,
    output logic        inst_rvalid_o,
    output logic        inst_rlast_o,
    input  logic        inst_rready_i,
    input  logic        data_cache_ena_i,
    input  logic        data_arvalid_i,
    input  logic [31:0] data_araddr_i,
    output logic        data_arready_o,
    output logic [31:0] data_rdata_o,
    output logic        data_rvalid_o,
    output logic        data_rlast_o,
    input  logic        data_rready_i,
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [3:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic [1:0]  arlock_o,
    output logic [3:0]  arcache_o,
    output logic [2:0]  arprot_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic        len_err_o
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_AR_INST = 3'd1;
    localparam logic [2:0] S_AR_DATA = 3'd2;
    localparam logic [2:0] S_R_INST  = 3'd3;
    localparam logic [2:0] S_R_DATA  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  arlen_q, arlen_d;
    logic [1:0]  arburst_q, arburst_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic        len_err_q, len_err_d;
    logic        grant_data, win_ena, r_inst, r_data, beat_ok;
    logic        unused_ok;

    assign unused_ok = ^{rid_i, rresp_i};

`ifdef AXI_ARB_RR_EN
    logic last_grant_q, last_grant_d;
    // last_grant 1 = data; on a tie the requester not served last wins
    assign grant_data = data_arvalid_i & (~inst_arvalid_i | ~last_grant_q);
    assign last_grant_d = (state_q == S_IDLE && (inst_arvalid_i || data_arvalid_i)) ? grant_data : last_grant_q;
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) last_grant_q <= 1'b0;
        else last_grant_q <= last_grant_d;
`else
    assign grant_data = data_arvalid_i;
`endif

    assign r_inst  = state_q == S_R_INST;
    assign r_data  = state_q == S_R_DATA;
    assign win_ena = grant_data ? data_cache_ena_i : inst_cache_ena_i;
    assign beat_ok = rvalid_i & rready_o;

    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arburst_d  = arburst_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        case (state_q)
            S_IDLE: if (inst_arvalid_i || data_arvalid_i) begin
                state_d   = grant_data ? S_AR_DATA : S_AR_INST;
                araddr_d  = grant_data ? data_araddr_i : inst_araddr_i;
                arlen_d   = win_ena ? (grant_data ? DATA_BURST_LEN : INST_BURST_LEN) : 4'd0;
                arburst_d = 2'b01;
            end
            S_AR_INST, S_AR_DATA: if (arready_i) begin
                state_d    = (state_q == S_AR_DATA) ? S_R_DATA : S_R_INST;
                beat_cnt_d = 4'd0;
            end
            S_R_INST, S_R_DATA: if (beat_ok) begin
                beat_cnt_d = beat_cnt_q + 4'd1;
                // beat_cnt holds beats already taken, so a legal last beat sees arlen
                if (rlast_i) begin
                    state_d   = S_IDLE;
                    len_err_d = len_err_q | (beat_cnt_q != arlen_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arburst_q  <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arburst_q  <= arburst_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign arid_o         = 4'd0;
    assign araddr_o       = araddr_q;
    assign arlen_o        = arlen_q;
    assign arsize_o       = 3'b010;
    assign arburst_o      = arburst_q;
    assign arlock_o       = 2'd0;
    assign arcache_o      = 4'd0;
    assign arprot_o       = 3'd0;
    assign arvalid_o      = state_q == S_AR_INST || state_q == S_AR_DATA;
    assign inst_arready_o = state_q == S_AR_INST && arready_i;
    assign data_arready_o = state_q == S_AR_DATA && arready_i;
    assign rready_o       = r_inst ? inst_rready_i : r_data ? data_rready_i : 1'b0;
    assign inst_rvalid_o  = r_inst & rvalid_i;
    assign inst_rlast_o   = r_inst & rlast_i;
    assign inst_rdata_o   = r_inst ? rdata_i : 32'd0;
    assign data_rvalid_o  = r_data & rvalid_i;
    assign data_rlast_o   = r_data & rlast_i;
    assign data_rdata_o   = r_data ? rdata_i : 32'd0;
    assign len_err_o      = len_err_q;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: scoreboard bench with a slave model serving grants in the expected order.
module tb_axi_read_arbiter;
    logic aclk = 1'b0;
    logic aresetn;
    logic inst_cache_ena_i, inst_arvalid_i, inst_rready_i;
    logic data_cache_ena_i, data_arvalid_i, data_rready_i;
    logic [31:0] inst_araddr_i, data_araddr_i;
    logic inst_arready_o, inst_rvalid_o, inst_rlast_o;
    logic data_arready_o, data_rvalid_o, data_rlast_o;
    logic [31:0] inst_rdata_o, data_rdata_o;
    logic [3:0] arid_o, arlen_o, arcache_o, rid_i;
    logic [31:0] araddr_o, rdata_i;
    logic [2:0] arsize_o, arprot_o;
    logic [1:0] arburst_o, arlock_o, rresp_i;
    logic arvalid_o, arready_i, rlast_i, rvalid_i, rready_o, len_err_o;

    typedef struct {bit owner; logic [31:0] addr; logic [3:0] len;} grant_t;
    typedef struct {bit owner; logic [31:0] data; bit last;} beat_t;
    grant_t gq[$];
    beat_t bq[$];
    int checks = 0, errors = 0;
    int inst_pend = 0, data_pend = 0;

    always #5 aclk = ~aclk;

    axi_read_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_cache_ena_i(inst_cache_ena_i), .inst_arvalid_i(inst_arvalid_i), .inst_araddr_i(inst_araddr_i),
        .inst_arready_o(inst_arready_o), .inst_rdata_o(inst_rdata_o), .inst_rvalid_o(inst_rvalid_o),
        .inst_rlast_o(inst_rlast_o), .inst_rready_i(inst_rready_i),
        .data_cache_ena_i(data_cache_ena_i), .data_arvalid_i(data_arvalid_i), .data_araddr_i(data_araddr_i),
        .data_arready_o(data_arready_o), .data_rdata_o(data_rdata_o), .data_rvalid_o(data_rvalid_o),
        .data_rlast_o(data_rlast_o), .data_rready_i(data_rready_i),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .arlock_o(arlock_o), .arcache_o(arcache_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
        .rready_o(rready_o), .len_err_o(len_err_o)
    );

    task automatic step;
        @(negedge aclk);
        #1;
    endtask

    task automatic init_inputs;
        inst_cache_ena_i = 0; inst_arvalid_i = 0; inst_araddr_i = 0; inst_rready_i = 1;
        data_cache_ena_i = 0; data_arvalid_i = 0; data_araddr_i = 0; data_rready_i = 1;
        arready_i = 0; rid_i = 4'hf; rdata_i = 0; rresp_i = 2'b10; rlast_i = 0; rvalid_i = 0;
        inst_pend = 0; data_pend = 0;
    endtask

    task automatic request(input bit owner, input int n, input logic [31:0] addr, input bit ena);
        if (owner) begin
            data_pend += n; data_araddr_i = addr; data_cache_ena_i = ena; data_arvalid_i = 1;
        end else begin
            inst_pend += n; inst_araddr_i = addr; inst_cache_ena_i = ena; inst_arvalid_i = 1;
        end
    endtask

    // nbeats < 0 sends the legal arlen+1 beats; stall_at >= 0 holds rready low 3 cycles before that beat
    task automatic serve(input int ardelay, input int nbeats, input int stall_at, output int waited);
        grant_t g;
        beat_t b;
        int n;
        waited = 0;
        while (!arvalid_o && waited < 20) begin step; waited++; end
        checks++;
        if (!arvalid_o || gq.size() == 0) begin
            errors++;
            $display("FAIL ar_wait arvalid_o=%0b pending_grants=%0d", arvalid_o, gq.size());
            return;
        end
        g = gq.pop_front();
        checks++;
        if ({araddr_o, arlen_o, arburst_o, arsize_o, arid_o, arlock_o, arcache_o, arprot_o} !==
            {g.addr, g.len, 2'b01, 3'b010, 4'd0, 2'd0, 4'd0, 3'd0}) begin
            errors++;
            $display("FAIL ar_fields addr=%h len=%0d burst=%b size=%b expected addr=%h len=%0d",
                     araddr_o, arlen_o, arburst_o, arsize_o, g.addr, g.len);
        end
        repeat (ardelay) step;
        arready_i = 1;
        #1;
        checks++;
        if ({arvalid_o, araddr_o, inst_arready_o, data_arready_o} !== {1'b1, g.addr, ~g.owner, g.owner}) begin
            errors++;
            $display("FAIL ar_handshake arvalid=%0b addr=%h i_ardy=%0b d_ardy=%0b expected owner=%0d addr=%h",
                     arvalid_o, araddr_o, inst_arready_o, data_arready_o, g.owner, g.addr);
        end
        step;
        arready_i = 0;
        if (g.owner) begin data_pend--; data_arvalid_i = data_pend > 0; end
        else begin inst_pend--; inst_arvalid_i = inst_pend > 0; end
        n = (nbeats < 0) ? int'(g.len) + 1 : nbeats;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                if (g.owner) data_rready_i = 0; else inst_rready_i = 0;
                rvalid_i = 1; rdata_i = 32'hdead_beef; rlast_i = 0;
                repeat (3) begin
                    #1;
                    checks++;
                    if (rready_o !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_rready rready_o=%0b expected 0", rready_o);
                    end
                    step;
                end
                data_rready_i = 1; inst_rready_i = 1;
            end
            rdata_i = $urandom; rlast_i = (i == n - 1); rvalid_i = 1;
            bq.push_back('{owner: g.owner, data: rdata_i, last: rlast_i});
            #1;
            b = bq.pop_front();
            checks++;
            if (b.owner ? ({data_rvalid_o, data_rdata_o, data_rlast_o, inst_rvalid_o, inst_rdata_o, rready_o} !==
                           {1'b1, b.data, b.last, 1'b0, 32'd0, 1'b1})
                        : ({inst_rvalid_o, inst_rdata_o, inst_rlast_o, data_rvalid_o, data_rdata_o, rready_o} !==
                           {1'b1, b.data, b.last, 1'b0, 32'd0, 1'b1})) begin
                errors++;
                $display("FAIL beat%0d i=%0b/%h/%0b d=%0b/%h/%0b rready=%0b expected owner=%0d data=%h last=%0b",
                         i, inst_rvalid_o, inst_rdata_o, inst_rlast_o, data_rvalid_o, data_rdata_o, data_rlast_o,
                         rready_o, b.owner, b.data, b.last);
            end
            step;
        end
        rvalid_i = 0; rlast_i = 0; rdata_i = 0;
        #1;
        checks++;
        if (arvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_gap arvalid_o=%0b expected 0", arvalid_o);
        end
    endtask

    task automatic check_len_err(input string name, input bit exp);
        checks++;
        if (len_err_o !== exp) begin
            errors++;
            $display("FAIL %s len_err_o=%0b expected %0b", name, len_err_o, exp);
        end
    endtask

    task automatic test_reset;
        init_inputs;
        aresetn = 0;
        step;
        checks++;
        if ({arvalid_o, rready_o, inst_arready_o, data_arready_o, inst_rvalid_o, data_rvalid_o,
             inst_rlast_o, data_rlast_o, len_err_o, araddr_o, arlen_o} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs arvalid=%0b rready=%0b len_err=%0b addr=%h len=%0d expected all 0",
                     arvalid_o, rready_o, len_err_o, araddr_o, arlen_o);
        end
        aresetn = 1;
        step;
    endtask

    task automatic test_inst_cached;
        int w;
        request(0, 1, 32'h1fc0_0000, 1);
        gq.push_back('{owner: 0, addr: 32'h1fc0_0000, len: 4'd15});
        serve(2, -1, -1, w);
        checks++;
        if (w != 1) begin errors++; $display("FAIL inst_ar_latency waited=%0d expected 1", w); end
        check_len_err("inst_cached", 0);
    endtask

    task automatic test_data_uncached;
        int w;
        request(1, 1, 32'hbfaf_8000, 0);
        gq.push_back('{owner: 1, addr: 32'hbfaf_8000, len: 4'd0});
        serve(0, -1, -1, w);
        check_len_err("data_uncached", 0);
    endtask

    task automatic test_back_to_back;
        int w;
        request(0, 2, 32'h0000_1000, 0);
        request(1, 2, 32'h0000_2000, 1);
`ifdef AXI_ARB_RR_EN
        gq.push_back('{owner: 1, addr: 32'h0000_2000, len: 4'd15});
        gq.push_back('{owner: 0, addr: 32'h0000_1000, len: 4'd0});
        gq.push_back('{owner: 1, addr: 32'h0000_2000, len: 4'd15});
        gq.push_back('{owner: 0, addr: 32'h0000_1000, len: 4'd0});
`else
        gq.push_back('{owner: 1, addr: 32'h0000_2000, len: 4'd15});
        gq.push_back('{owner: 1, addr: 32'h0000_2000, len: 4'd15});
        gq.push_back('{owner: 0, addr: 32'h0000_1000, len: 4'd0});
        gq.push_back('{owner: 0, addr: 32'h0000_1000, len: 4'd0});
`endif
        for (int k = 0; k < 4; k++) begin
            serve(1, -1, -1, w);
            checks++;
            if (w != 1) begin errors++; $display("FAIL b2b_gap%0d waited=%0d expected 1", k, w); end
        end
        check_len_err("back_to_back", 0);
    endtask

    task automatic test_stall;
        int w;
        request(0, 1, 32'h1fc0_0040, 1);
        gq.push_back('{owner: 0, addr: 32'h1fc0_0040, len: 4'd15});
        serve(1, -1, 5, w);
        check_len_err("stall", 0);
    endtask

    task automatic test_short_burst;
        int w;
        request(1, 1, 32'h8000_0100, 1);
        gq.push_back('{owner: 1, addr: 32'h8000_0100, len: 4'd15});
        serve(0, 8, -1, w);
        check_len_err("short_burst", 1);
        request(0, 1, 32'h1fc0_0080, 0);
        gq.push_back('{owner: 0, addr: 32'h1fc0_0080, len: 4'd0});
        serve(0, -1, -1, w);
        check_len_err("len_err_sticky", 1);
    endtask

    task automatic test_reset_mid_burst;
        int w = 0;
        request(0, 1, 32'h1fc0_00c0, 1);
        while (!arvalid_o && w < 20) begin step; w++; end
        arready_i = 1;
        step;
        arready_i = 0; inst_arvalid_i = 0;
        rvalid_i = 1; rdata_i = 32'h1234_5678; rlast_i = 0;
        step;
        step;
        checks++;
        if (inst_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_beat inst_rvalid_o=%0b expected 1", inst_rvalid_o);
        end
        aresetn = 0;
        #1;
        checks++;
        if ({arvalid_o, rready_o, inst_arready_o, data_arready_o, inst_rvalid_o, data_rvalid_o,
             inst_rlast_o, data_rlast_o, len_err_o, araddr_o, arlen_o, inst_rdata_o} !== 77'd0) begin
            errors++;
            $display("FAIL mid_burst_reset rready=%0b i_rvalid=%0b len_err=%0b addr=%h len=%0d rdata=%h expected all 0",
                     rready_o, inst_rvalid_o, len_err_o, araddr_o, arlen_o, inst_rdata_o);
        end
        init_inputs;
        step;
        aresetn = 1;
        step;
    endtask

    initial begin
        test_reset;
        test_inst_cached;
        test_data_uncached;
        test_back_to_back;
        test_stall;
        test_short_burst;
        test_reset_mid_burst;
        checks++;
        if (gq.size() != 0) begin errors++; $display("FAIL grants_left %0d expected 0", gq.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
